// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: 32-step shift-add multiply or
// restoring divide over one shared 33-bit add/subtract path, then sign fix-up.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       Md_op,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Read_req,
  input  logic             Flush,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nx;

  logic [CW-1:0]    counter;
  logic             op_div, neg_main, neg_rem, div0;
  logic [WIDTH-1:0] opnd;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc;   // product high half or partial remainder
  logic [WIDTH-1:0] sr;    // multiplier bits out / quotient bits in

  // Request decode for the accepting edge.
  logic             start_md, is_div, sign_a, sign_b;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign start_md = (state == IDLE) && Start && !Md_op[2] && !Flush;
  assign is_div   = Md_op[1];
  assign sign_a   = !Md_op[0] && A_in[WIDTH-1];
  assign sign_b   = !Md_op[0] && B_in[WIDTH-1];
  assign a_mag    = sign_a ? -A_in : A_in;
  assign b_mag    = sign_b ? -B_in : B_in;

  // Shared adder: top bit of add_res is the carry, i.e. "no borrow" when subtracting.
  logic [WIDTH:0]   add_x, add_y;
  logic             add_sub;
  logic [WIDTH+1:0] add_res;

  assign add_sub = op_div;
  assign add_x   = op_div ? {acc, sr[WIDTH-1]} : {1'b0, acc};
  assign add_y   = (op_div || sr[0]) ? {1'b0, opnd} : '0;
  assign add_res = {1'b0, add_x} + {1'b0, add_y ^ {(WIDTH+1){add_sub}}}
                 + {{(WIDTH+1){1'b0}}, add_sub};

  // Sign fix-up applied while in FIX.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_next, lo_next;

  always_comb begin
    prod     = {acc, sr};
    prod_fix = neg_main ? -prod : prod;
    quo_fix  = div0 ? '1 : (neg_main ? -sr : sr);
    rem_fix  = neg_rem ? -acc : acc;
    hi_next  = op_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    lo_next  = op_div ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (Start && !Md_op[2]) state_nx = CALC;
      CALC:    if (counter == LAST)    state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (Flush) state_nx = IDLE;
  end

  always_comb begin
    Busy  = (state != IDLE);
    Done  = (state == FIX);
    Stall = Busy && (Read_req || Start);
  end

  always_ff @(posedge clk) begin
    if (rst || Flush)          counter <= '0;
    else if (state == CALC)    counter <= counter + 1'b1;
    else if (start_md)         counter <= '0;
  end

  // NOTE: datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (start_md) begin
      op_div   <= is_div;
      neg_main <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div0     <= is_div && (B_in == '0);
      opnd     <= is_div ? b_mag : a_mag;
      sr       <= is_div ? a_mag : b_mag;
      acc      <= '0;
    end else if (state == CALC) begin
      if (op_div) begin
        acc <= add_res[WIDTH+1] ? add_res[WIDTH-1:0] : add_x[WIDTH-1:0];
        sr  <= {sr[WIDTH-2:0], add_res[WIDTH+1]};
      end else begin
        acc <= add_res[WIDTH:1];
        sr  <= {add_res[0], sr[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Hi_out <= '0;
      Lo_out <= '0;
    end else if (!Flush) begin
      if (state == FIX) begin
        Hi_out <= hi_next;
        Lo_out <= lo_next;
      end else if (state == IDLE && Start && Md_op == 3'b100) begin
        Hi_out <= A_in;
      end else if (state == IDLE && Start && Md_op == 3'b101) begin
        Lo_out <= A_in;
      end
    end
  end

endmodule
